// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared mode encodings and popcount helper for the switch debouncer
package sw_pkg;

  localparam logic MODE_LEVEL  = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Wide enough to count all 32 possible channels.
  localparam int POP_W = 6;

  // Number of set bits; callers zero-extend narrower vectors to 32 bits.
  function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_db_chan.sv
// rtl/sw_db_chan.sv - two-flop synchroniser, debounce counter and stable level for one switch
module sw_db_chan #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_stable_nxt,
  output logic o_press_nxt,
  output logic o_rise
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_rise;

  logic w_accept;
  logic w_stable_nxt;
  logic w_press_nxt;

  // A new level is accepted when it has differed from stable long enough;
  // the next-state values are exported so the top can register its outputs
  // on the same edge that stable changes.
  always_comb begin
    w_accept     = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);
    w_stable_nxt = w_accept ? r_sync2 : r_stable;
    w_press_nxt  = w_accept && r_sync2;
  end

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter restarts whenever the input agrees with stable, so a
  // short excursion leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_stable <= w_stable_nxt;
      r_rise   <= w_press_nxt;
    end
  end

  assign o_stable_nxt = w_stable_nxt;
  assign o_press_nxt  = w_press_nxt;
  assign o_rise       = r_rise;

endmodule

// File: rtl/sw_debounce_cnt.sv
// rtl/sw_debounce_cnt.sv - debounced switch bank with level/toggle LED drive and press counter
module sw_debounce_cnt
  import sw_pkg::*;
#(
  parameter int N_SW      = 8,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw,
  input  logic             mode,
  input  logic             clr,
  output logic [N_SW-1:0]  out,
  output logic [N_SW-1:0]  rise,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_SW-1:0]  w_stable_nxt;
  logic [N_SW-1:0]  w_press;
  logic [N_SW-1:0]  w_tog_nxt;
  logic [31:0]      w_press32;
  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_SW-1:0]  r_tog;

  for (genvar g = 0; g < N_SW; g++) begin : g_chan
    sw_db_chan #(
      .DB_CYCLES(DB_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_sw        (sw[g]),
      .o_stable_nxt(w_stable_nxt[g]),
      .o_press_nxt (w_press[g]),
      .o_rise      (rise[g])
    );
  end

  // Toggle and counter next state; clr overrides any presses on the same edge.
  always_comb begin
    w_press32           = '0;
    w_press32[N_SW-1:0] = w_press;
    w_pop               = popcount(w_press32);
    w_sum               = SUM_W'(press_cnt) + SUM_W'(w_pop);
    w_tog_nxt           = clr ? '0 : (r_tog ^ w_press);
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (w_sum > SUM_W'(CNT_MAX)) begin
      w_cnt_nxt = CNT_MAX;
    end else begin
      w_cnt_nxt = w_sum[CNT_W-1:0];
    end
  end

  // Toggle state, registered LED mux and saturating press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tog     <= '0;
      out       <= '0;
      press_cnt <= '0;
    end else begin
      r_tog     <= w_tog_nxt;
      out       <= (mode == MODE_TOGGLE) ? w_tog_nxt : w_stable_nxt;
      press_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sw_debounce_cnt.sv
// tb/tb_sw_debounce_cnt.sv - scoreboard bench for sw_debounce_cnt with DB_CYCLES=4, N_SW=8, CNT_W=4
module tb_sw_debounce_cnt;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       mode;
  logic       clr;
  logic [7:0] out;
  logic [7:0] rise;
  logic [3:0] press_cnt;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] out;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  sw_debounce_cnt #(
    .N_SW     (8),
    .DB_CYCLES(4),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .mode     (mode),
    .clr      (clr),
    .out      (out),
    .rise     (rise),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every rise pulse must match the oldest scheduled expectation.
  always @(negedge clk) begin
    if (rise !== 8'h00) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rise cyc=%0d got=%h expected=none", cyc, rise);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc !== mon_e.cyc || rise !== mon_e.rise || out !== mon_e.out || press_cnt !== mon_e.cnt) begin
          bad++;
          $display("FAIL rise_event got cyc=%0d rise=%h out=%h cnt=%0d expected cyc=%0d rise=%h out=%h cnt=%0d",
                   cyc, rise, out, press_cnt, mon_e.cyc, mon_e.rise, mon_e.out, mon_e.cnt);
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic [7:0] r, input logic [7:0] o, input logic [3:0] n);
    exp_t e;
    e.cyc  = c;
    e.rise = r;
    e.out  = o;
    e.cnt  = n;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    sw    = 8'h00;
    mode  = 1'b0;
    clr   = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    total++;
    if (out !== 8'h00 || rise !== 8'h00 || press_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_state got out=%h rise=%h cnt=%0d expected 00 00 0", out, rise, press_cnt);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_level;
    int c;
    @(negedge clk);
    c  = cyc;
    sw = 8'h05;
    push_exp(c + 6, 8'h05, 8'h05, 4'd2);
    tick(8);
    total++;
    if (out !== 8'h05 || rise !== 8'h00 || press_cnt !== 4'd2) begin
      bad++;
      $display("FAIL level_hold got out=%h rise=%h cnt=%0d expected 05 00 2", out, rise, press_cnt);
    end
    sw = 8'h00;
    tick(8);
    total++;
    if (out !== 8'h00 || press_cnt !== 4'd2) begin
      bad++;
      $display("FAIL level_release got out=%h cnt=%0d expected 00 2", out, press_cnt);
    end
  endtask

  task automatic test_glitch;
    int c;
    @(negedge clk);
    sw = 8'h08;
    tick(3);
    sw = 8'h00;
    tick(10);
    total++;
    if (out !== 8'h00 || press_cnt !== 4'd2) begin
      bad++;
      $display("FAIL glitch_reject got out=%h cnt=%0d expected 00 2", out, press_cnt);
    end
    c  = cyc;
    sw = 8'h08;
    push_exp(c + 6, 8'h08, 8'h08, 4'd3);
    tick(4);
    sw = 8'h00;
    tick(12);
    total++;
    if (out !== 8'h00 || press_cnt !== 4'd3) begin
      bad++;
      $display("FAIL glitch_accept got out=%h cnt=%0d expected 00 3", out, press_cnt);
    end
  endtask

  task automatic test_toggle;
    int         c;
    logic [7:0] t;
    mode = 1'b1;
    @(negedge clk);
    total++;
    if (out !== 8'h0D) begin
      bad++;
      $display("FAIL toggle_entry got out=%h expected 0d", out);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (out !== 8'h00 || press_cnt !== 4'd0) begin
      bad++;
      $display("FAIL toggle_clr got out=%h cnt=%0d expected 00 0", out, press_cnt);
    end
    t = 8'h00;
    for (int k = 0; k < 3; k++) begin
      c  = cyc;
      sw = 8'h01;
      t  = t ^ 8'h01;
      push_exp(c + 6, 8'h01, t, 4'(k + 1));
      tick(8);
      sw = 8'h00;
      tick(8);
      total++;
      if (out !== t || press_cnt !== 4'(k + 1)) begin
        bad++;
        $display("FAIL toggle_step%0d got out=%h cnt=%0d expected %h %0d", k, out, press_cnt, t, k + 1);
      end
    end
    mode = 1'b0;
    @(negedge clk);
    total++;
    if (out !== 8'h00) begin
      bad++;
      $display("FAIL mode_to_level got out=%h expected 00", out);
    end
    mode = 1'b1;
    @(negedge clk);
    total++;
    if (out !== 8'h01) begin
      bad++;
      $display("FAIL tog_retained got out=%h expected 01", out);
    end
    mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int         c;
    logic [4:0] n;
    n = 5'd3;
    for (int k = 0; k < 20; k++) begin
      c  = cyc;
      sw = 8'h02;
      n  = (n >= 5'd15) ? 5'd15 : n + 5'd1;
      push_exp(c + 6, 8'h02, 8'h02, n[3:0]);
      tick(7);
      sw = 8'h00;
      tick(7);
    end
    total++;
    if (press_cnt !== 4'd15) begin
      bad++;
      $display("FAIL saturate got cnt=%0d expected 15", press_cnt);
    end
    c  = cyc;
    sw = 8'h60;
    push_exp(c + 6, 8'h60, 8'h60, 4'd15);
    tick(8);
    total++;
    if (press_cnt !== 4'd15) begin
      bad++;
      $display("FAIL saturate_multi got cnt=%0d expected 15", press_cnt);
    end
    sw = 8'h00;
    tick(8);
    c  = cyc;
    sw = 8'h10;
    push_exp(c + 6, 8'h10, 8'h10, 4'd0);
    tick(5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (press_cnt !== 4'd0 || rise !== 8'h10) begin
      bad++;
      $display("FAIL clr_with_press got cnt=%0d rise=%h expected 0 10", press_cnt, rise);
    end
    mode = 1'b1;
    @(negedge clk);
    total++;
    if (out !== 8'h00) begin
      bad++;
      $display("FAIL clr_tog got out=%h expected 00", out);
    end
    mode = 1'b0;
    sw   = 8'h00;
    tick(8);
  endtask

  task automatic test_reset_mid;
    int c;
    @(negedge clk);
    sw = 8'h80;
    tick(3);
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 8'h00 || rise !== 8'h00 || press_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_assert got out=%h rise=%h cnt=%0d expected 00 00 0", out, rise, press_cnt);
    end
    tick(4);
    total++;
    if (out !== 8'h00 || rise !== 8'h00 || press_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_hold got out=%h rise=%h cnt=%0d expected 00 00 0", out, rise, press_cnt);
    end
    c     = cyc;
    rst_n = 1'b1;
    push_exp(c + 6, 8'h80, 8'h80, 4'd1);
    tick(10);
    total++;
    if (out !== 8'h80 || press_cnt !== 4'd1) begin
      bad++;
      $display("FAIL reset_mid_after got out=%h cnt=%0d expected 80 1", out, press_cnt);
    end
    sw = 8'h00;
    tick(8);
  endtask

  initial begin
    test_reset;
    test_level;
    test_glitch;
    test_toggle;
    test_saturation;
    test_reset_mid;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_rise got pending=%0d expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
